// File: rtl/mem_stage_ctrl_pkg.sv
// Shared widths, payload layout and state encoding for the memory-access stage.
package mem_stage_ctrl_pkg;

    localparam int TO_MEM_DATA_W = 75;
    localparam int TO_WB_DATA_W  = 70;
    localparam int MEM_FWD_W     = 38;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } mem_state_e;

    // The EX->MEM bus carries one spare top bit above the named fields.
    typedef struct packed {
        logic        pad;
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic        rd_1b;
        logic        rd_2b;
        logic        rd_4b;
        logic        rd_signed;
        logic [4:0]  dest;
        logic        gr_we;
    } mem_payload_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects the addressed byte/halfword and sign- or zero-extends it.
module mem_load_align (
    input  logic [31:0] raw,
    input  logic [1:0]  off,
    input  logic        rd_1b,
    input  logic        rd_2b,
    input  logic        rd_4b,
    input  logic        rd_signed,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        // Halfword alignment is guaranteed upstream, so only off[1] matters.
        half_sel = off[1] ? raw[31:16] : raw[15:0];

        load_data = '0;
        if (rd_1b)
            load_data = {{24{rd_signed & byte_sel[7]}}, byte_sel};
        else if (rd_2b)
            load_data = {{16{rd_signed & half_sel[15]}}, half_sel};
        else if (rd_4b)
            load_data = raw;
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-access pipeline stage: holds one instruction, waits for load data, buffers it
// when write-back stalls, and drives the write-back payload and decode forwarding bus.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     WB_allow_in,
    input  logic                     EX_to_MEM_valid,
    input  logic [TO_MEM_DATA_W-1:0] to_MEM_data,
    output logic                     MEM_allow_in,
    output logic                     MEM_to_WB_valid,
    output logic [TO_WB_DATA_W-1:0]  to_WB_data,
    input  logic [31:0]              data_sram_rdata,
    input  logic                     data_sram_data_ok,
    output logic [MEM_FWD_W-1:0]     MEM_forward
);

    mem_state_e   state_q, state_d;
    mem_payload_t in_pl;
    mem_payload_t payload_p0;
    logic         vld_p0;
    logic [31:0]  rdata_p0;

    logic         accept;
    logic         is_load;
    logic         is_load_new;
    logic         mem_ready_go;
    logic         mem_busy;
    logic [31:0]  raw;
    logic [31:0]  load_data;
    logic [31:0]  final_result;
    logic         unused_pad;

    assign in_pl       = to_MEM_data;
    assign is_load_new = in_pl.rd_1b | in_pl.rd_2b | in_pl.rd_4b;
    assign is_load     = payload_p0.rd_1b | payload_p0.rd_2b | payload_p0.rd_4b;
    assign raw         = (state_q == S_HOLD) ? rdata_p0 : data_sram_rdata;
    assign unused_pad  = payload_p0.pad;

    mem_load_align u_align (
        .raw       (raw),
        .off       (payload_p0.alu_result[1:0]),
        .rd_1b     (payload_p0.rd_1b),
        .rd_2b     (payload_p0.rd_2b),
        .rd_4b     (payload_p0.rd_4b),
        .rd_signed (payload_p0.rd_signed),
        .load_data (load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // A new instruction always wins; otherwise only load completion moves the FSM.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = is_load_new ? S_WAIT : S_IDLE;
        end else begin
            case (state_q)
                S_WAIT:  if (data_sram_data_ok) state_d = WB_allow_in ? S_IDLE : S_HOLD;
                S_HOLD:  if (WB_allow_in)       state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        mem_ready_go    = ~vld_p0 | ~is_load
                        | ((state_q == S_WAIT) & data_sram_data_ok)
                        | (state_q == S_HOLD);
        MEM_allow_in    = ~vld_p0 | (mem_ready_go & WB_allow_in);
        MEM_to_WB_valid = vld_p0 & mem_ready_go;
        accept          = EX_to_MEM_valid & MEM_allow_in;
        final_result    = is_load ? load_data : payload_p0.alu_result;
        mem_busy        = vld_p0 & is_load & ~mem_ready_go;
        to_WB_data      = {payload_p0.pc, final_result, payload_p0.dest, payload_p0.gr_we};
        MEM_forward     = {payload_p0.dest & {5{vld_p0}}, final_result, mem_busy};
    end

    // ---- p0: stage register, plus response buffer while write-back is blocked ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0     <= 1'b0;
            payload_p0 <= '0;
            rdata_p0   <= '0;
        end else begin
            if (MEM_allow_in)
                vld_p0 <= EX_to_MEM_valid;
            if (accept)
                payload_p0 <= in_pl;
            if ((state_q == S_WAIT) && (state_d == S_HOLD))
                rdata_p0 <= data_sram_rdata;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: behavioural instruction-level model checked every cycle
// plus directed vectors with hand-computed values.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        WB_allow_in;
    logic        EX_to_MEM_valid;
    logic [74:0] to_MEM_data;
    logic        MEM_allow_in;
    logic        MEM_to_WB_valid;
    logic [69:0] to_WB_data;
    logic [31:0] data_sram_rdata;
    logic        data_sram_data_ok;
    logic [37:0] MEM_forward;

    int checks   = 0;
    int failures = 0;

    mem_stage_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .WB_allow_in       (WB_allow_in),
        .EX_to_MEM_valid   (EX_to_MEM_valid),
        .to_MEM_data       (to_MEM_data),
        .MEM_allow_in      (MEM_allow_in),
        .MEM_to_WB_valid   (MEM_to_WB_valid),
        .to_WB_data        (to_WB_data),
        .data_sram_rdata   (data_sram_rdata),
        .data_sram_data_ok (data_sram_data_ok),
        .MEM_forward       (MEM_forward)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [74:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                       input logic b1, input logic b2, input logic b4,
                                       input logic sgn, input logic [4:0] dest, input logic we);
        return {1'b0, pc, alu, b1, b2, b4, sgn, dest, we};
    endfunction

    function automatic logic [31:0] ref_align(input logic [31:0] raw, input logic [1:0] off,
                                              input logic b1, input logic b2, input logic b4,
                                              input logic sgn);
        logic [31:0] v;
        v = 32'd0;
        if (b1) begin
            v = (raw >> (8 * int'(off))) & 32'h0000_00FF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (b2) begin
            v = (raw >> (off[1] ? 16 : 0)) & 32'h0000_FFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end else if (b4) begin
            v = raw;
        end
        return v;
    endfunction

    // Model: the instruction held, whether its load data is already captured, and that data.
    bit          m_valid = 1'b0;
    bit          m_have  = 1'b0;
    logic [74:0] m_instr = '0;
    logic [31:0] m_data  = '0;

    logic        m_load;
    logic        e_ready, e_allow, e_wbvalid;
    logic [31:0] e_final;
    logic [37:0] e_fwd;
    logic [69:0] e_wbdata;

    always_comb begin
        m_load    = m_instr[9] | m_instr[8] | m_instr[7];
        e_ready   = !m_valid || !m_load || m_have || data_sram_data_ok;
        e_allow   = !m_valid || (e_ready && WB_allow_in);
        e_wbvalid = m_valid && e_ready;
        e_final   = m_load ? ref_align(m_have ? m_data : data_sram_rdata, m_instr[11:10],
                                       m_instr[9], m_instr[8], m_instr[7], m_instr[6])
                           : m_instr[41:10];
        e_fwd     = {(m_valid ? m_instr[5:1] : 5'd0), e_final, (m_valid && m_load && !e_ready)};
        e_wbdata  = {m_instr[73:42], e_final, m_instr[5:1], m_instr[0]};
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = 1'b0;
            m_have  = 1'b0;
            m_instr = '0;
            m_data  = '0;
        end else begin
            bit acc, cap, leave;
            acc   = EX_to_MEM_valid && e_allow;
            cap   = m_valid && m_load && !m_have && data_sram_data_ok && !WB_allow_in;
            leave = e_wbvalid && WB_allow_in;
            if (cap) begin
                m_have = 1'b1;
                m_data = data_sram_rdata;
            end
            if (leave) m_have = 1'b0;
            if (e_allow) m_valid = EX_to_MEM_valid;
            if (acc) begin
                m_instr = to_MEM_data;
                m_have  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("allow_in", {69'd0, MEM_allow_in}, {69'd0, e_allow});
        chk("wb_valid", {69'd0, MEM_to_WB_valid}, {69'd0, e_wbvalid});
        chk("to_wb_data", to_WB_data, e_wbdata);
        chk("forward", {32'd0, MEM_forward}, {32'd0, e_fwd});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        WB_allow_in = 1'b1;
        EX_to_MEM_valid = 1'b0;
        to_MEM_data = '0;
        data_sram_rdata = '0;
        data_sram_data_ok = 1'b0;

        @(negedge clk);
        chk("rst_allow", {69'd0, MEM_allow_in}, 70'd1);
        chk("rst_valid", {69'd0, MEM_to_WB_valid}, 70'd0);
        chk("rst_fwd", {32'd0, MEM_forward}, 70'd0);
        step();
        reset = 1'b0;

        // non-load passes straight through
        EX_to_MEM_valid = 1'b1;
        to_MEM_data = mk(32'h100, 32'h0000_1234, 0, 0, 0, 0, 5'd5, 1);
        step();
        EX_to_MEM_valid = 1'b0;
        @(negedge clk);
        chk("nl_valid", {69'd0, MEM_to_WB_valid}, 70'd1);
        chk("nl_final", {38'd0, to_WB_data[37:6]}, 70'h1234);
        chk("nl_fwd", {32'd0, MEM_forward}, {32'd0, 5'd5, 32'h0000_1234, 1'b0});

        // ld.b signed, offset 3, one wait cycle
        step();
        EX_to_MEM_valid = 1'b1;
        to_MEM_data = mk(32'h104, 32'h0000_2003, 1, 0, 0, 1, 5'd6, 1);
        step();
        EX_to_MEM_valid = 1'b0;
        @(negedge clk);
        chk("ldb_busy", {69'd0, MEM_forward[0]}, 70'd1);
        chk("ldb_allow", {69'd0, MEM_allow_in}, 70'd0);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h80FF_0000;
        @(negedge clk);
        chk("ldb_final", {38'd0, to_WB_data[37:6]}, 70'hFFFF_FF80);
        chk("ldb_valid", {69'd0, MEM_to_WB_valid}, 70'd1);

        // ld.hu offset 2 with write-back stalled: data must be held
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        EX_to_MEM_valid = 1'b1;
        to_MEM_data = mk(32'h108, 32'h0000_3002, 0, 1, 0, 0, 5'd7, 1);
        step();
        EX_to_MEM_valid = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hBEEF_1234;
        WB_allow_in = 1'b0;
        @(negedge clk);
        chk("ldh_valid_stall", {69'd0, MEM_to_WB_valid}, 70'd1);
        chk("ldh_allow_stall", {69'd0, MEM_allow_in}, 70'd0);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        @(negedge clk);
        chk("ldh_hold_final", {38'd0, to_WB_data[37:6]}, 70'h0000_BEEF);
        step();
        WB_allow_in = 1'b1;
        @(negedge clk);
        chk("ldh_rel_final", {38'd0, to_WB_data[37:6]}, 70'h0000_BEEF);
        chk("ldh_rel_allow", {69'd0, MEM_allow_in}, 70'd1);

        // back-to-back: load completes while a non-load is accepted
        step();
        EX_to_MEM_valid = 1'b1;
        to_MEM_data = mk(32'h10C, 32'h0000_4000, 0, 0, 1, 0, 5'd8, 1);
        step();
        to_MEM_data = mk(32'h110, 32'h0000_0055, 0, 0, 0, 0, 5'd9, 1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("b2b_final", {38'd0, to_WB_data[37:6]}, 70'hCAFE_F00D);
        chk("b2b_allow", {69'd0, MEM_allow_in}, 70'd1);
        step();
        EX_to_MEM_valid = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        @(negedge clk);
        chk("b2b_pc", {38'd0, to_WB_data[69:38]}, 70'h110);
        chk("b2b_final2", {38'd0, to_WB_data[37:6]}, 70'h55);
        chk("b2b_valid", {69'd0, MEM_to_WB_valid}, 70'd1);

        // spurious data_ok with the stage empty
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("spur_valid", {69'd0, MEM_to_WB_valid}, 70'd0);
        chk("spur_final", {38'd0, to_WB_data[37:6]}, 70'h55);
        step();
        data_sram_data_ok = 1'b0;

        // asynchronous reset while a load waits
        EX_to_MEM_valid = 1'b1;
        to_MEM_data = mk(32'h114, 32'h0000_5001, 1, 0, 0, 0, 5'd10, 1);
        step();
        EX_to_MEM_valid = 1'b0;
        #2;
        chk("rw_busy", {69'd0, MEM_forward[0]}, 70'd1);
        reset = 1'b1;
        #1;
        chk("rw_valid", {69'd0, MEM_to_WB_valid}, 70'd0);
        chk("rw_allow", {69'd0, MEM_allow_in}, 70'd1);
        step();
        step();
        reset = 1'b0;
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rw_late_ok", {69'd0, MEM_to_WB_valid}, 70'd0);
        step();
        data_sram_data_ok = 1'b0;

        // sweep of sizes, offsets and signedness, some with a write-back stall
        for (int sz = 0; sz < 3; sz++) begin
            for (int off = 0; off < 4; off++) begin
                for (int sg = 0; sg < 2; sg++) begin
                    int idx;
                    bit w;
                    idx = sz * 8 + off * 2 + sg;
                    w   = (idx % 3) != 0;
                    EX_to_MEM_valid = 1'b1;
                    to_MEM_data = mk(32'h200 + 32'(idx * 4), 32'h6000 + 32'(off),
                                     sz == 0, sz == 1, sz == 2, sg[0], 5'(idx), 1'b1);
                    WB_allow_in = 1'b1;
                    step();
                    EX_to_MEM_valid = 1'b0;
                    data_sram_data_ok = 1'b1;
                    data_sram_rdata = $urandom;
                    WB_allow_in = w;
                    step();
                    data_sram_data_ok = 1'b0;
                    if (!w) begin
                        data_sram_rdata = $urandom;
                        WB_allow_in = 1'b1;
                        step();
                    end
                end
            end
        end
        WB_allow_in = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
